reg_file_mp: RTL

- Parametrised multi-port integer register file for the RISC-V core. Next generation of the single-write, two-read register file.
- Adds the following over that block:
  - configurable width, depth and read-port count
  - a second write port
  - optional write-to-read bypass
  - a debug read port
  - a sequenced bulk-clear engine with a busy/done handshake
- Sits between the decode stage (reads) and the writeback stage (writes).

---
 rtl/reg_file_mp_if.sv | 39 +++
 rtl/reg_file_mp.sv | 119 +++++++++++
 2 files changed

// File: rtl/reg_file_mp_if.sv
// ----------------------------------------------------------------------------
// reg_file_mp_if : write/read/debug/clear bundle of the multi-port register file
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     wen_a;
   logic [ADDR_W-1:0]        waddr_a;
   logic [DATA_W-1:0]        wdata_a;
   logic                     wen_b;
   logic [ADDR_W-1:0]        waddr_b;
   logic [DATA_W-1:0]        wdata_b;
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [ADDR_W-1:0]        dbg_addr;
   logic [DATA_W-1:0]        dbg_data;
   logic                     clr_req;
   logic                     clr_busy;
   logic                     clr_done;

   modport master (
      output wen_a, waddr_a, wdata_a, wen_b, waddr_b, wdata_b,
      output raddr, dbg_addr, clr_req,
      input  rdata, dbg_data, clr_busy, clr_done
   );

   modport slave (
      input  wen_a, waddr_a, wdata_a, wen_b, waddr_b, wdata_b,
      input  raddr, dbg_addr, clr_req,
      output rdata, dbg_data, clr_busy, clr_done
   );
endinterface

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ----------------------------------------------------------------------------
// reg_file_mp : dual-write, multi-read register file with bypass, debug port
//               and a sequenced bulk-clear engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_file_mp #(
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = 5,
   parameter int                NUM_RD  = 2,
   parameter int                SP_IDX  = 2,
   parameter logic [DATA_W-1:0] SP_INIT = 32'h7fffefe4,
   parameter int                BYPASS  = 1
) (
   input wire logic     clk,
   input wire logic     rst,
   reg_file_mp_if.slave bus
);

   localparam int                DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_top  = ADDR_W'(DEPTH-1);
   localparam logic [ADDR_W-1:0] c_sp   = ADDR_W'(SP_IDX);
   localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_regs [0:DEPTH-1];

   logic                      w_byp_en;
   logic [NUM_RD*DATA_W-1:0]  w_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
         r_state <= S_IDLE;
         r_idx   <= c_one;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // Port B is applied last so it wins an address collision with A.
         if (r_state != S_CLEAR) begin
            if (bus.wen_a && (bus.waddr_a != '0)) r_regs[bus.waddr_a] <= bus.wdata_a;
            if (bus.wen_b && (bus.waddr_b != '0)) r_regs[bus.waddr_b] <= bus.wdata_b;
         end
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.clr_req) begin
                  r_state <= S_CLEAR;
                  r_idx   <= c_one;
                  r_busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_regs[r_idx] <= (r_idx == c_sp) ? SP_INIT : '0;
               if (r_idx == c_top) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + c_one;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign w_byp_en = (BYPASS != 0) && (r_state == S_IDLE);

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;

      assign w_addr = bus.raddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
         w_data = r_regs[w_addr];
         if (w_addr == '0) begin
            w_data = '0;
         end else if (w_byp_en) begin
            if (bus.wen_b && (bus.waddr_b == w_addr)) begin
               w_data = bus.wdata_b;
            end else if (bus.wen_a && (bus.waddr_a == w_addr)) begin
               w_data = bus.wdata_a;
            end
         end
      end

      assign w_rdata[gi*DATA_W +: DATA_W] = w_data;
   end

   assign bus.rdata    = w_rdata;
   assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : r_regs[bus.dbg_addr];
   assign bus.clr_busy = r_busy;
   assign bus.clr_done = r_done;

endmodule

`default_nettype wire
